// File: rtl/ifu_pkg.sv
// Shared fetch-side types and helpers.
// Halfword type, RVC classification, reset PC.
package ifu_pkg;

  typedef logic [15:0] hw_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  function automatic logic is_rvc(hw_t h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ifu_hw_queue.sv
// Halfword shift queue for the fetch aligner.
// Pops 0/1/2 from the head, then appends 0/1/2.
module ifu_hw_queue
  import ifu_pkg::*;
#(
  parameter int BUF_HW = 4,
  parameter int CW     = $clog2(BUF_HW + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [1:0]    push_n,
  input  hw_t           push_hw0,
  input  hw_t           push_hw1,
  input  logic [1:0]    pop_n,
  output logic [CW-1:0] cnt,
  output hw_t           head0,
  output hw_t           head1
);

  hw_t           q     [BUF_HW];
  hw_t           q_nxt [BUF_HW];
  hw_t           ext   [BUF_HW+3];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] base;
  logic [CW-1:0] cnt_nxt;

  // shift out popped entries, then append at the new tail
  always_comb begin
    base    = cnt_q - CW'(pop_n);
    cnt_nxt = base + CW'(push_n);
    for (int i = 0; i < BUF_HW + 3; i++) begin
      ext[i] = (i < BUF_HW) ? q[i] : '0;
    end
    for (int i = 0; i < BUF_HW; i++) begin
      q_nxt[i] = ext[i + int'(pop_n)];
      if (push_n != 2'd0 && i == int'(base)) begin
        q_nxt[i] = push_hw0;
      end
      if (push_n == 2'd2 && i == int'(base) + 1) begin
        q_nxt[i] = push_hw1;
      end
    end
  end

  // occupancy; clear discards everything
  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_nxt;
  end

  // storage needs no reset; cnt qualifies it
  always_ff @(posedge clk) begin
    for (int i = 0; i < BUF_HW; i++) begin
      q[i] <= q_nxt[i];
    end
  end

  assign cnt   = cnt_q;
  assign head0 = q[0];
  assign head1 = q[1];

endmodule

// File: rtl/ifu_align.sv
// Fetch-side instruction aligner.
// Splits fetch words into RVC / 32b instructions.
module ifu_align
  import ifu_pkg::*;
#(
  parameter int          BUF_HW   = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        comp
);

  localparam int CW = $clog2(BUF_HW + 1);
  localparam logic [CW-1:0] LIM = CW'(BUF_HW - 2);

  logic [CW-1:0] cnt;
  hw_t           head0;
  hw_t           head1;
  logic [31:0]   pc;
  logic          drop_first;
  logic          push;
  logic          pop;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  hw_t           push_hw0;
  logic          unused_bit0;

  assign unused_bit0 = redirect_pc[0];

  ifu_hw_queue #(
    .BUF_HW (BUF_HW),
    .CW     (CW)
  ) u_q (
    .clk      (clk),
    .clr      (rst | flush),
    .push_n   (push_n),
    .push_hw0 (push_hw0),
    .push_hw1 (fetch_data[31:16]),
    .pop_n    (pop_n),
    .cnt      (cnt),
    .head0    (head0),
    .head1    (head1)
  );

  // handshakes from registered occupancy and head class
  always_comb begin
    comp        = is_rvc(head0);
    fetch_ready = !rst && !flush && (cnt <= LIM);
    instr_valid = !rst && !flush &&
                  ((cnt != '0 && comp) || cnt > CW'(1));
    instr       = comp ? {16'h0, head0} : {head1, head0};
    instr_pc    = pc;
    push        = fetch_valid && fetch_ready;
    pop         = instr_valid && instr_ready;
    push_hw0    = drop_first ? fetch_data[31:16] : fetch_data[15:0];
    push_n      = !push ? 2'd0 : (drop_first ? 2'd1 : 2'd2);
    pop_n       = !pop ? 2'd0 : (comp ? 2'd1 : 2'd2);
  end

  // PC tracking: reset, redirect, or advance on pop
  always_ff @(posedge clk) begin
    if (rst)        pc <= RESET_PC;
    else if (flush) pc <= {redirect_pc[31:1], 1'b0};
    else if (pop)   pc <= pc + (comp ? 32'd2 : 32'd4);
  end

  // drop the low half of the first word after a mid-word redirect
  always_ff @(posedge clk) begin
    if (rst)        drop_first <= 1'b0;
    else if (flush) drop_first <= redirect_pc[1];
    else if (push)  drop_first <= 1'b0;
  end

endmodule

// File: tb/tb_ifu_align.sv
// Directed bench for ifu_align.
// Table vectors plus a PC wrap sequence.
module tb_ifu_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        comp;

  int n_chk  = 0;
  int n_fail = 0;

  ifu_align #(
    .BUF_HW   (4),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .comp        (comp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        f;
    logic [31:0] rpc;
    logic        fv;
    logic [31:0] fd;
    logic        ir;
    logic        efr;
    logic        eiv;
    logic [31:0] ei;
    logic [31:0] epc;
    logic        ec;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic r, input logic f, input logic [31:0] rpc,
    input logic fv, input logic [31:0] fd, input logic ir,
    input logic efr, input logic eiv,
    input logic [31:0] ei, input logic [31:0] epc, input logic ec);
    vec_t v;
    v.r = r; v.f = f; v.rpc = rpc; v.fv = fv; v.fd = fd;
    v.ir = ir; v.efr = efr; v.eiv = eiv;
    v.ei = ei; v.epc = epc; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; redirect_pc = '0;
    fetch_valid = 1'b0; fetch_data = '0; instr_ready = 1'b0;

    // r f rpc fv fd ir | efr eiv ei epc ec
    // reset with fetch offered
    tv.push_back(mk(1,0,0,1,32'h0013_0013,1, 0,0,0,0,0));
    // 32b words from RESET_PC
    tv.push_back(mk(0,0,0,1,32'h0013_0013,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'h0023_0023,1,
                    1,1,32'h0013_0013,32'h8000_0000,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0023_0023,32'h8000_0004,0));
    // two c.li
    tv.push_back(mk(0,0,0,1,32'h4501_4501,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0000_4501,32'h8000_0008,1));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0000_4501,32'h8000_000A,1));
    // straddling 32b instruction
    tv.push_back(mk(0,0,0,1,32'h0093_4501,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0000_4501,32'h8000_000C,1));
    tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'hABCD_0513,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    0,1,32'h0513_0093,32'h8000_000E,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0000_ABCD,32'h8000_0012,1));
    // backpressure
    tv.push_back(mk(0,0,0,1,32'h0033_0033,0, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'h0043_0043,0,
                    1,1,32'h0033_0033,32'h8000_0014,0));
    tv.push_back(mk(0,0,0,1,32'h0053_0053,0,
                    0,1,32'h0033_0033,32'h8000_0014,0));
    tv.push_back(mk(0,0,0,1,32'h0053_0053,1,
                    0,1,32'h0033_0033,32'h8000_0014,0));
    tv.push_back(mk(0,0,0,1,32'h0053_0053,1,
                    1,1,32'h0043_0043,32'h8000_0018,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0053_0053,32'h8000_001C,0));
    // flush with buffered data, drop low half
    tv.push_back(mk(0,0,0,1,32'h4501_4501,0, 1,0,0,0,0));
    tv.push_back(mk(0,1,32'h8000_0102,0,0,1, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'h4505_DEAD,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0000_4505,32'h8000_0102,1));
    // back-to-back flushes; bit 0 of redirect ignored
    tv.push_back(mk(0,1,32'h8000_0202,0,0,1, 0,0,0,0,0));
    tv.push_back(mk(0,1,32'h8000_0301,1,32'h1111_1111,1, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'h0063_0063,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0063_0063,32'h8000_0300,0));
    // rst beats flush
    tv.push_back(mk(1,1,32'h1234_5678,0,0,1, 0,0,0,0,0));
    // build cnt=3 then reset with fetch offered
    tv.push_back(mk(0,0,0,1,32'h4501_4501,0, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'h0073_4501,1,
                    1,1,32'h0000_4501,32'h8000_0000,1));
    tv.push_back(mk(1,0,0,1,32'h1111_1111,1, 0,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,1,32'h0083_0083,1, 1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,0,1,
                    1,1,32'h0083_0083,32'h8000_0000,0));
    tv.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst         = tv[i].r;
      flush       = tv[i].f;
      redirect_pc = tv[i].rpc;
      fetch_valid = tv[i].fv;
      fetch_data  = tv[i].fd;
      instr_ready = tv[i].ir;
      #1;
      chk($sformatf("v%0d fetch_ready", i), 32'(fetch_ready), 32'(tv[i].efr));
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(tv[i].eiv));
      if (tv[i].eiv) begin
        chk($sformatf("v%0d instr", i), instr, tv[i].ei);
        chk($sformatf("v%0d instr_pc", i), instr_pc, tv[i].epc);
        chk($sformatf("v%0d comp", i), 32'(comp), 32'(tv[i].ec));
      end
    end

    // PC wrap across 2^32 after a mid-word redirect
    @(negedge clk);
    rst = 1'b0; flush = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    fetch_valid = 1'b0; instr_ready = 1'b0;
    #1;
    chk("wrap flush handshake", {30'h0, fetch_ready, instr_valid}, 32'h0);
    @(negedge clk);
    flush = 1'b0; fetch_valid = 1'b1; fetch_data = 32'h4501_0000;
    #1;
    chk("wrap fetch_ready", 32'(fetch_ready), 32'h1);
    @(negedge clk);
    fetch_data = 32'h0000_0001; instr_ready = 1'b1;
    #1;
    chk("wrap instr_valid", 32'(instr_valid), 32'h1);
    chk("wrap instr", instr, 32'h0000_4501);
    chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFE);
    @(negedge clk);
    fetch_valid = 1'b0;
    begin
      int waited;
      waited = 0;
      #1;
      while (!instr_valid && waited < 4) begin
        @(negedge clk);
        #1;
        waited++;
      end
      chk("wrap second valid timeout", 32'(instr_valid), 32'h1);
    end
    chk("wrap second instr", instr, 32'h0000_0001);
    chk("wrap second pc", instr_pc, 32'h0000_0000);
    chk("wrap second comp", 32'(comp), 32'h1);
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    chk("wrap third pc", instr_pc, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
